// File: rtl/scan_chain_responder.sv
// scan_chain_responder
// On-chip end of a full-scan interface. An NFF-bit state register either
// captures functional next-state (NbarT=0) or shifts serially Si -> So
// (NbarT=1). A shift counter and length checker report whether every
// scan burst was exactly NFF shifts long.
// Optional feature macro: SCAN_MISR_EN adds a MISR over the So stream
// (ports sig_clr / signature).
module scan_chain_responder #(
  parameter int               NFF       = 56,
  parameter int               CW        = 8,
  parameter logic [NFF-1:0]   RESET_VAL = '0,
  parameter int               SIG_W     = 16,
  parameter logic [SIG_W-1:0] SIG_POLY  = 16'h8016
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           NbarT,
  input  logic           Si,
  output logic           So,
  input  logic           func_en,
  input  logic [NFF-1:0] d_func,
  output logic [NFF-1:0] q_func,
  output logic [CW-1:0]  shift_cnt,
  output logic           shift_done,
  output logic           shift_err
`ifdef SCAN_MISR_EN
  ,
  input  logic             sig_clr,
  output logic [SIG_W-1:0] signature
`endif
);

  typedef enum logic {NORMAL = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] NFF_CNT = CW'(NFF);

  state_t         state;
  state_t         state_next;
  logic [NFF-1:0] q_next;
  logic [CW-1:0]  cnt_next;
  logic           done_next;
  logic           err_next;

  // So is simply the chain's tail bit, so it moves on the same edge as a shift
  assign So = q_func[0];

  // State register: remembers whether the previous edge was in shift mode
  always_ff @(posedge clk) begin
    if (reset) state <= NORMAL;
    else       state <= state_next;
  end

  // Next-state: the mode just follows NbarT as sampled at each edge
  always_comb begin
    state_next = NORMAL;
    if (NbarT) state_next = SHIFT;
  end

  // Datapath next values: shift or capture, count the burst, judge its length on exit
  always_comb begin
    q_next    = q_func;
    cnt_next  = shift_cnt;
    done_next = 1'b0;
    err_next  = shift_err;
    if (NbarT) begin
      q_next = {Si, q_func[NFF-1:1]};
      if (state == NORMAL) begin
        cnt_next = CW'(1);
      end else if (shift_cnt != CNT_MAX) begin
        cnt_next = shift_cnt + 1'b1;
      end
    end else begin
      if (func_en) q_next = d_func;
      if (state == SHIFT) begin
        if (shift_cnt == NFF_CNT) done_next = 1'b1;
        else                      err_next  = 1'b1;
      end
    end
  end

  // Datapath registers; reset wins even in the middle of a burst
  always_ff @(posedge clk) begin
    if (reset) begin
      q_func     <= RESET_VAL;
      shift_cnt  <= '0;
      shift_done <= 1'b0;
      shift_err  <= 1'b0;
    end else begin
      q_func     <= q_next;
      shift_cnt  <= cnt_next;
      shift_done <= done_next;
      shift_err  <= err_next;
    end
  end

`ifdef SCAN_MISR_EN
  logic [SIG_W-1:0] sig_next;

  // MISR step: compress the bit leaving on So at every shift edge
  always_comb begin
    sig_next = signature;
    if (sig_clr) begin
      sig_next = '0;
    end else if (NbarT) begin
      sig_next = {signature[SIG_W-2:0], 1'b0}
               ^ (signature[SIG_W-1] ? SIG_POLY : '0)
               ^ {{(SIG_W-1){1'b0}}, So};
    end
  end

  // Signature register; reset and clear both beat a shift
  always_ff @(posedge clk) begin
    if (reset) signature <= '0;
    else       signature <= sig_next;
  end
`endif

endmodule

// File: tb/tb_scan_chain_responder.sv
// tb_scan_chain_responder
// Directed and randomized checks of scan_chain_responder (NFF=8, CW=4)
// against a queue-based reference model of the scan chain. Define
// SCAN_MISR_EN to also exercise the signature register.
module tb_scan_chain_responder;

  localparam int NFF = 8;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           NbarT = 1'b0;
  logic           Si = 1'b0;
  logic           So;
  logic           func_en = 1'b0;
  logic [NFF-1:0] d_func = '0;
  logic [NFF-1:0] q_func;
  logic [CW-1:0]  shift_cnt;
  logic           shift_done;
  logic           shift_err;
`ifdef SCAN_MISR_EN
  logic           sig_clr = 1'b0;
  logic [15:0]    signature;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: chain as a bit queue, element 0 is the So end
  bit        chain[$];
  int        m_burst;
  bit        m_in_burst;
  bit        m_done;
  bit        m_err;
  bit [15:0] m_sig;

  scan_chain_responder #(
    .NFF(NFF), .CW(CW), .RESET_VAL(8'h00), .SIG_W(16), .SIG_POLY(16'h8016)
  ) dut (
    .clk(clk), .reset(reset), .NbarT(NbarT), .Si(Si), .So(So),
    .func_en(func_en), .d_func(d_func), .q_func(q_func),
    .shift_cnt(shift_cnt), .shift_done(shift_done), .shift_err(shift_err)
`ifdef SCAN_MISR_EN
    , .sig_clr(sig_clr), .signature(signature)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [NFF-1:0] model_q();
    logic [NFF-1:0] v;
    v = '0;
    for (int i = 0; i < NFF; i++) v[i] = chain[i];
    return v;
  endfunction

  function automatic void model_load(input logic [NFF-1:0] d);
    chain.delete();
    for (int i = 0; i < NFF; i++) chain.push_back(d[i]);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".q_func"}, 32'(q_func), 32'(model_q()));
    checkOutput({tag, ".So"}, 32'(So), 32'(chain[0]));
    checkOutput({tag, ".shift_cnt"}, 32'(shift_cnt), 32'(m_burst));
    checkOutput({tag, ".shift_done"}, 32'(shift_done), 32'(m_done));
    checkOutput({tag, ".shift_err"}, 32'(shift_err), 32'(m_err));
`ifdef SCAN_MISR_EN
    checkOutput({tag, ".signature"}, 32'(signature), 32'(m_sig));
`endif
  endtask

  // One clock: drive inputs, advance the model over the edge, check 1 time unit later
  task automatic applyStimulus(input string tag, input bit rst, input bit nb, input bit si,
                               input bit fen, input logic [NFF-1:0] d, input bit clr);
    bit so_bit;
    reset = rst; NbarT = nb; Si = si; func_en = fen; d_func = d;
`ifdef SCAN_MISR_EN
    sig_clr = clr;
`endif
    @(posedge clk);
    so_bit = chain[0];
    if (rst) begin
      model_load('0);
      m_burst = 0; m_in_burst = 0; m_done = 0; m_err = 0; m_sig = 0;
    end else begin
      if (clr) m_sig = 0;
      else if (nb) m_sig = (m_sig << 1) ^ (m_sig[15] ? 16'h8016 : 16'h0000) ^ 16'(so_bit);
      m_done = 0;
      if (nb) begin
        void'(chain.pop_front());
        chain.push_back(si);
        m_burst = m_in_burst ? ((m_burst + 1 > 15) ? 15 : m_burst + 1) : 1;
        m_in_burst = 1;
      end else begin
        if (m_in_burst) begin
          if (m_burst == NFF) m_done = 1;
          else m_err = 1;
        end
        m_in_burst = 0;
        if (fen) model_load(d);
      end
    end
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] exp_so;
    int len;

    model_load('0);
    m_burst = 0; m_in_burst = 0; m_done = 0; m_err = 0; m_sig = 0;

    // Reset state
    applyStimulus("reset", 1, 0, 0, 0, 8'h00, 0);
    checkOutput("reset.q_zero", 32'(q_func), 32'h0);

    // Test 1: load pattern via 8 shifts, So must be all zeros beforehand
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      checkOutput("t1.so_pre", 32'(So), 32'h0);
      applyStimulus("t1.shift", 0, 1, pat[i], 0, 8'h00, 0);
    end
    checkOutput("t1.q_4D", 32'(q_func), 32'h4D);
    applyStimulus("t1.exit", 0, 0, 0, 0, 8'h00, 0);
    checkOutput("t1.done", 32'(shift_done), 32'h1);
    checkOutput("t1.cnt8", 32'(shift_cnt), 32'h8);
    applyStimulus("t1.after", 0, 0, 0, 0, 8'h00, 0);
    checkOutput("t1.done_pulse", 32'(shift_done), 32'h0);

    // Test 2: capture A5, then unload LSB first while loading zeros
    applyStimulus("t2.cap", 0, 0, 0, 1, 8'hA5, 0);
    checkOutput("t2.q_A5", 32'(q_func), 32'hA5);
    exp_so = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      checkOutput("t2.so_seq", 32'(So), 32'(exp_so[i]));
      applyStimulus("t2.shift", 0, 1, 0, 0, 8'h00, 0);
    end
    checkOutput("t2.q_00", 32'(q_func), 32'h00);
    applyStimulus("t2.exit", 0, 0, 0, 0, 8'h00, 0);

    // Test 3: short burst sets sticky error; a good burst still pulses done
    for (int i = 0; i < 5; i++) applyStimulus("t3.short", 0, 1, 1, 0, 8'h00, 0);
    applyStimulus("t3.exit", 0, 0, 0, 0, 8'h00, 0);
    checkOutput("t3.err", 32'(shift_err), 32'h1);
    checkOutput("t3.cnt5", 32'(shift_cnt), 32'h5);
    checkOutput("t3.nodone", 32'(shift_done), 32'h0);
    for (int i = 0; i < 8; i++) applyStimulus("t3.good", 0, 1, 0, 0, 8'h00, 0);
    applyStimulus("t3.exit2", 0, 0, 0, 0, 8'h00, 0);
    checkOutput("t3.done2", 32'(shift_done), 32'h1);
    checkOutput("t3.err_sticky", 32'(shift_err), 32'h1);

    // Test 4: reset mid-burst, then an overlong burst saturates the counter
    for (int i = 0; i < 3; i++) applyStimulus("t4.pre", 0, 1, 1, 0, 8'h00, 0);
    applyStimulus("t4.rst", 1, 1, 1, 0, 8'h00, 0);
    checkOutput("t4.rst_q", 32'(q_func), 32'h0);
    checkOutput("t4.rst_cnt", 32'(shift_cnt), 32'h0);
    checkOutput("t4.rst_err", 32'(shift_err), 32'h0);
    for (int i = 0; i < 20; i++) applyStimulus("t4.long", 0, 1, i[0], 0, 8'h00, 0);
    checkOutput("t4.sat", 32'(shift_cnt), 32'hF);
    applyStimulus("t4.exit", 0, 0, 0, 0, 8'h00, 0);
    checkOutput("t4.err", 32'(shift_err), 32'h1);

    // Test 5: hold with func_en=0; d_func/func_en ignored while shifting
    applyStimulus("t5.cap", 1, 0, 0, 0, 8'h00, 0);
    applyStimulus("t5.cap", 0, 0, 0, 1, 8'h3C, 0);
    for (int i = 0; i < 3; i++) applyStimulus("t5.hold", 0, 0, 1, 0, 8'($urandom), 0);
    checkOutput("t5.q_hold", 32'(q_func), 32'h3C);
    for (int i = 0; i < 8; i++) applyStimulus("t5.shift", 0, 1, 1, 1, 8'($urandom), 0);
    checkOutput("t5.q_FF", 32'(q_func), 32'hFF);
    applyStimulus("t5.exit", 0, 0, 0, 0, 8'h00, 0);

`ifdef SCAN_MISR_EN
    // Test 6: MISR over eight ones with no feedback reached yet
    applyStimulus("t6.clr", 0, 0, 0, 1, 8'hFF, 1);
    for (int i = 0; i < 8; i++) applyStimulus("t6.shift", 0, 1, 0, 0, 8'h00, 0);
    checkOutput("t6.sig", 32'(signature), 32'h00FF);
    applyStimulus("t6.exit", 0, 0, 0, 0, 8'h00, 0);
    applyStimulus("t6.clr2", 0, 0, 0, 0, 8'h00, 1);
    checkOutput("t6.sig_zero", 32'(signature), 32'h0);
`endif

    // Randomized: bursts of random length mixed with random capture/hold cycles
    applyStimulus("rnd.rst", 1, 0, 0, 0, 8'h00, 0);
    for (int b = 0; b < 40; b++) begin
      len = (($urandom_range(0, 1) == 1) ? NFF : $urandom_range(1, 18));
      for (int i = 0; i < len; i++)
        applyStimulus("rnd.shift", 0, 1, 1'($urandom), 1'($urandom), 8'($urandom),
                      ($urandom_range(0, 15) == 0));
      for (int i = 0; i < $urandom_range(1, 3); i++)
        applyStimulus("rnd.norm", 0, 0, 1'($urandom), 1'($urandom), 8'($urandom),
                      ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 9) == 0) applyStimulus("rnd.rst", 1, 1'($urandom), 0, 0, 8'h00, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
